// File: rtl/issue_scoreboard_if.sv
// Decode/retire handshake bundle between the decode stage and issue_scoreboard.
// The master side (decode and write-back) drives requests; the scoreboard answers with grant and stall.
interface issue_scoreboard_if;
  logic       issue_valid_i;
  logic [4:0] issue_rs1_i;
  logic       issue_rs1_read_i;
  logic [4:0] issue_rs2_i;
  logic       issue_rs2_read_i;
  logic [4:0] issue_rd_i;
  logic       issue_write_i;
  logic [2:0] issue_unit_i;
  logic       issue_serialize_i;
  logic       issue_grant_o;
  logic       stall_decode_o;
  logic       retire_valid_i;
  logic [4:0] retire_rd_i;
  logic       retire_write_i;
  logic       ai_done_i;
  logic       crypto_done_i;
  logic       flush_i;

  modport master (
    output issue_valid_i, issue_rs1_i, issue_rs1_read_i, issue_rs2_i, issue_rs2_read_i,
           issue_rd_i, issue_write_i, issue_unit_i, issue_serialize_i,
           retire_valid_i, retire_rd_i, retire_write_i, ai_done_i, crypto_done_i, flush_i,
    input  issue_grant_o, stall_decode_o
  );

  modport slave (
    input  issue_valid_i, issue_rs1_i, issue_rs1_read_i, issue_rs2_i, issue_rs2_read_i,
           issue_rd_i, issue_write_i, issue_unit_i, issue_serialize_i,
           retire_valid_i, retire_rd_i, retire_write_i, ai_done_i, crypto_done_i, flush_i,
    output issue_grant_o, stall_decode_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: GPR pending bits, AI/crypto busy tracking, in-flight count and drain/serialize FSM.
// Optional macro SCB_RETIRE_BYPASS_EN lets a same-cycle retire hide its rd from the hazard check.
//
// state  | meaning
// RUN    | normal issue
// DRAIN  | flush seen; wait for in-flight work and busy units to empty, then clear pending
// SERIAL | serializing instruction issued; hold issue until everything has retired
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  issue_scoreboard_if.slave  bus,
  output logic [31:0]        pending_o,
  output logic [CNT_W-1:0]   inflight_o,
  output logic [1:0]         state_o,
  output logic               underflow_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             ai_busy_q, ai_busy_d;
  logic             crypto_busy_q, crypto_busy_d;
  logic             underflow_q, underflow_d;

  logic [31:0] retire_mask;
  logic [31:0] pend_eff;
  logic        rs1_haz, rs2_haz, waw_haz, unit_busy;
  logic        inflight_room, serial_ok, grant;
  logic        retire_ok, drain_exit;

  assign retire_mask = (bus.retire_valid_i && bus.retire_write_i) ? (32'd1 << bus.retire_rd_i) : 32'd0;

`ifdef SCB_RETIRE_BYPASS_EN
  assign pend_eff = pending_q & ~retire_mask;
`else
  assign pend_eff = pending_q;
`endif

  // x0 is never marked pending, but the explicit index checks keep it hazard-free regardless
  assign rs1_haz = bus.issue_rs1_read_i && (bus.issue_rs1_i != 5'd0) && pend_eff[bus.issue_rs1_i];
  assign rs2_haz = bus.issue_rs2_read_i && (bus.issue_rs2_i != 5'd0) && pend_eff[bus.issue_rs2_i];
  assign waw_haz = bus.issue_write_i && (bus.issue_rd_i != 5'd0) && pend_eff[bus.issue_rd_i];

  assign unit_busy = ((bus.issue_unit_i == 3'd2) && ai_busy_q) ||
                     ((bus.issue_unit_i == 3'd3) && crypto_busy_q);

  assign inflight_room = (inflight_q < CNT_W'(MAX_INFLIGHT));
  assign serial_ok     = !bus.issue_serialize_i || (inflight_q == '0);

  assign grant = bus.issue_valid_i && (state_q == ST_RUN) && !bus.flush_i &&
                 !rs1_haz && !rs2_haz && !waw_haz && !unit_busy &&
                 inflight_room && serial_ok;

  assign bus.issue_grant_o  = grant;
  assign bus.stall_decode_o = bus.issue_valid_i && !grant;

  always_comb begin
    state_d    = state_q;
    drain_exit = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.flush_i)                            state_d = ST_DRAIN;
        else if (grant && bus.issue_serialize_i)    state_d = ST_SERIAL;
      end
      ST_SERIAL: begin
        if (bus.flush_i)                            state_d = ST_DRAIN;
        else if (inflight_q == '0)                  state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (!bus.flush_i && (inflight_q == '0) && !ai_busy_q && !crypto_busy_q) begin
          state_d    = ST_RUN;
          drain_exit = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // set wins over a same-cycle clear of the same register
  always_comb begin
    pending_d = pending_q & ~retire_mask;
    if (grant && bus.issue_write_i && (bus.issue_rd_i != 5'd0))
      pending_d = pending_d | (32'd1 << bus.issue_rd_i);
    if (drain_exit)
      pending_d = 32'd0;
    pending_d[0] = 1'b0;
  end

  // a retire with nothing in flight is an error: it is flagged and does not decrement
  always_comb begin
    underflow_d = underflow_q;
    retire_ok   = bus.retire_valid_i && (inflight_q != '0);
    if (bus.retire_valid_i && (inflight_q == '0))
      underflow_d = 1'b1;
    inflight_d = inflight_q;
    if (grant && !retire_ok)
      inflight_d = inflight_q + CNT_W'(1);
    else if (!grant && retire_ok)
      inflight_d = inflight_q - CNT_W'(1);
  end

  always_comb begin
    ai_busy_d = ai_busy_q;
    if (grant && (bus.issue_unit_i == 3'd2))
      ai_busy_d = 1'b1;
    else if (bus.ai_done_i)
      ai_busy_d = 1'b0;
    crypto_busy_d = crypto_busy_q;
    if (grant && (bus.issue_unit_i == 3'd3))
      crypto_busy_d = 1'b1;
    else if (bus.crypto_done_i)
      crypto_busy_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      pending_q     <= 32'd0;
      inflight_q    <= '0;
      ai_busy_q     <= 1'b0;
      crypto_busy_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      inflight_q    <= inflight_d;
      ai_busy_q     <= ai_busy_d;
      crypto_busy_q <= crypto_busy_d;
      underflow_q   <= underflow_d;
    end
  end

  assign pending_o   = pending_q;
  assign inflight_o  = inflight_q;
  assign state_o     = state_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus random traffic against a reference model.
module tb_issue_scoreboard;
  localparam int MAX   = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [31:0]      pending;
  logic [CNT_W-1:0] inflight;
  logic [1:0]       state;
  logic             underflow;

  issue_scoreboard_if bus ();

  issue_scoreboard #(.MAX_INFLIGHT(MAX), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .pending_o   (pending),
    .inflight_o  (inflight),
    .state_o     (state),
    .underflow_o (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference model: plain per-register flags and integer counts
  bit m_pend[32];
  int m_inf;
  bit m_ai, m_cr, m_uf;
  int m_st;               // 0 run, 1 drain, 2 serial
  bit exp_g, act_g, act_stall;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_inf = 0; m_ai = 0; m_cr = 0; m_uf = 0; m_st = 0;
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit m_blocked(int r);
    bit bypassed;
    bypassed = 1'b0;
`ifdef SCB_RETIRE_BYPASS_EN
    bypassed = bus.retire_valid_i && bus.retire_write_i && (int'(bus.retire_rd_i) == r);
`endif
    return (r != 0) && m_pend[r] && !bypassed;
  endfunction

  function automatic bit m_grant();
    if (!bus.issue_valid_i || m_st != 0 || bus.flush_i) return 1'b0;
    if (bus.issue_rs1_read_i && m_blocked(int'(bus.issue_rs1_i))) return 1'b0;
    if (bus.issue_rs2_read_i && m_blocked(int'(bus.issue_rs2_i))) return 1'b0;
    if (bus.issue_write_i && m_blocked(int'(bus.issue_rd_i))) return 1'b0;
    if (bus.issue_unit_i == 3'd2 && m_ai) return 1'b0;
    if (bus.issue_unit_i == 3'd3 && m_cr) return 1'b0;
    if (m_inf >= MAX) return 1'b0;
    if (bus.issue_serialize_i && m_inf != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_update(bit g);
    int  nst, ninf;
    bit  clear_all, nai, ncr;
    nst = m_st; clear_all = 1'b0;
    if (m_st == 0) begin
      if (bus.flush_i) nst = 1;
      else if (g && bus.issue_serialize_i) nst = 2;
    end else if (m_st == 2) begin
      if (bus.flush_i) nst = 1;
      else if (m_inf == 0) nst = 0;
    end else begin
      if (!bus.flush_i && m_inf == 0 && !m_ai && !m_cr) begin
        nst = 0; clear_all = 1'b1;
      end
    end
    ninf = m_inf + (g ? 1 : 0);
    if (bus.retire_valid_i) begin
      if (m_inf == 0) m_uf = 1'b1;
      else ninf = ninf - 1;
    end
    nai = (g && bus.issue_unit_i == 3'd2) ? 1'b1 : (bus.ai_done_i ? 1'b0 : m_ai);
    ncr = (g && bus.issue_unit_i == 3'd3) ? 1'b1 : (bus.crypto_done_i ? 1'b0 : m_cr);
    if (bus.retire_valid_i && bus.retire_write_i) m_pend[bus.retire_rd_i] = 1'b0;
    if (g && bus.issue_write_i && bus.issue_rd_i != 5'd0) m_pend[bus.issue_rd_i] = 1'b1;
    if (clear_all) for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_st = nst; m_inf = ninf; m_ai = nai; m_cr = ncr;
  endfunction

  task automatic clr_in();
    bus.issue_valid_i = 0; bus.issue_rs1_i = 0; bus.issue_rs1_read_i = 0;
    bus.issue_rs2_i = 0; bus.issue_rs2_read_i = 0; bus.issue_rd_i = 0;
    bus.issue_write_i = 0; bus.issue_unit_i = 0; bus.issue_serialize_i = 0;
    bus.retire_valid_i = 0; bus.retire_rd_i = 0; bus.retire_write_i = 0;
    bus.ai_done_i = 0; bus.crypto_done_i = 0; bus.flush_i = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wr, input logic [2:0] unit, input logic ser);
    bus.issue_valid_i = 1; bus.issue_rd_i = rd; bus.issue_write_i = wr;
    bus.issue_unit_i = unit; bus.issue_serialize_i = ser;
  endtask

  task automatic retire(input logic [4:0] rd, input logic wr);
    bus.retire_valid_i = 1; bus.retire_rd_i = rd; bus.retire_write_i = wr;
  endtask

  // inputs are driven just after a falling edge; sample combinational outputs, clock, update model
  task automatic tick();
    #1;
    exp_g = m_grant(); act_g = bus.issue_grant_o; act_stall = bus.stall_decode_o;
    @(posedge clk);
    m_update(exp_g);
    #1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr_in(); rst = 1; m_reset();
    #3;
    nvec++; if (pending !== 32'd0) begin nerr++; $display("FAIL reset_pending got %h want 0", pending); end
    nvec++; if (inflight !== 4'd0) begin nerr++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    nvec++; if (state !== 2'd0 || underflow !== 1'b0) begin nerr++; $display("FAIL reset_state got st=%0d uf=%0b want 0/0", state, underflow); end
    @(negedge clk); rst = 0; @(negedge clk);
  endtask

  task automatic test_raw();
    clr_in(); issue(5'd5, 1, 3'd0, 0); tick();
    nvec++; if (act_g !== 1'b1 || pending !== 32'h20) begin nerr++; $display("FAIL raw_first got g=%0b pend=%h want 1/00000020", act_g, pending); end
    clr_in(); issue(5'd0, 0, 3'd0, 0); bus.issue_rs1_i = 5; bus.issue_rs1_read_i = 1;
    repeat (2) begin
      tick();
      nvec++; if (act_stall !== 1'b1) begin nerr++; $display("FAIL raw_stall got %0b want 1", act_stall); end
    end
    retire(5'd5, 1); tick();
`ifdef SCB_RETIRE_BYPASS_EN
    nvec++; if (act_g !== 1'b1) begin nerr++; $display("FAIL raw_bypass_grant got %0b want 1", act_g); end
`else
    nvec++; if (act_g !== 1'b0) begin nerr++; $display("FAIL raw_retire_cycle got %0b want 0", act_g); end
    bus.retire_valid_i = 0; tick();
    nvec++; if (act_g !== 1'b1) begin nerr++; $display("FAIL raw_after_retire got %0b want 1", act_g); end
`endif
    nvec++; if (pending !== 32'd0 || inflight !== 4'd1) begin nerr++; $display("FAIL raw_end got pend=%h inf=%0d want 0/1", pending, inflight); end
    clr_in(); retire(5'd0, 0); tick(); clr_in();
  endtask

  task automatic test_rd0_limit();
    clr_in(); issue(5'd0, 1, 3'd0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      nvec++; if (act_g !== 1'b1 || inflight !== CNT_W'(i) || pending !== 32'd0) begin
        nerr++; $display("FAIL rd0_fill got g=%0b inf=%0d pend=%h want 1/%0d/0", act_g, inflight, pending, i);
      end
    end
    tick();
    nvec++; if (act_stall !== 1'b1 || inflight !== 4'd4) begin nerr++; $display("FAIL rd0_full got stall=%0b inf=%0d want 1/4", act_stall, inflight); end
    retire(5'd0, 0); tick();
    nvec++; if (act_g !== 1'b0 || inflight !== 4'd3) begin nerr++; $display("FAIL rd0_retire got g=%0b inf=%0d want 0/3", act_g, inflight); end
    bus.retire_valid_i = 0; tick();
    nvec++; if (act_g !== 1'b1 || inflight !== 4'd4) begin nerr++; $display("FAIL rd0_regrant got g=%0b inf=%0d want 1/4", act_g, inflight); end
    clr_in(); retire(5'd0, 0); repeat (4) tick();
    nvec++; if (inflight !== 4'd0) begin nerr++; $display("FAIL rd0_drain got %0d want 0", inflight); end
    clr_in();
  endtask

  task automatic test_ai_busy();
    clr_in(); issue(5'd0, 0, 3'd2, 0); tick();
    nvec++; if (act_g !== 1'b1) begin nerr++; $display("FAIL ai_first got %0b want 1", act_g); end
    repeat (2) begin
      tick();
      nvec++; if (act_stall !== 1'b1) begin nerr++; $display("FAIL ai_busy_stall got %0b want 1", act_stall); end
    end
    bus.ai_done_i = 1; tick();
    nvec++; if (act_g !== 1'b0) begin nerr++; $display("FAIL ai_done_cycle got %0b want 0", act_g); end
    tick();
    nvec++; if (act_g !== 1'b1) begin nerr++; $display("FAIL ai_grant_with_done got %0b want 1", act_g); end
    bus.ai_done_i = 0; tick();
    nvec++; if (act_stall !== 1'b1) begin nerr++; $display("FAIL ai_still_busy got %0b want 1", act_stall); end
    clr_in(); bus.ai_done_i = 1; tick();
    clr_in(); retire(5'd0, 0); repeat (2) tick(); clr_in();
  endtask

  task automatic test_serial();
    clr_in(); issue(5'd0, 0, 3'd0, 0); repeat (2) tick();
    issue(5'd0, 0, 3'd0, 1); tick();
    nvec++; if (act_stall !== 1'b1) begin nerr++; $display("FAIL ser_wait got %0b want 1", act_stall); end
    retire(5'd0, 0); repeat (2) tick();
    nvec++; if (act_g !== 1'b0 || inflight !== 4'd0) begin nerr++; $display("FAIL ser_drain got g=%0b inf=%0d want 0/0", act_g, inflight); end
    bus.retire_valid_i = 0; tick();
    nvec++; if (act_g !== 1'b1 || state !== 2'd2) begin nerr++; $display("FAIL ser_grant got g=%0b st=%0d want 1/2", act_g, state); end
    issue(5'd0, 0, 3'd0, 0); tick();
    nvec++; if (act_g !== 1'b0) begin nerr++; $display("FAIL ser_block got %0b want 0", act_g); end
    retire(5'd0, 0); tick();
    nvec++; if (act_g !== 1'b0 || state !== 2'd2) begin nerr++; $display("FAIL ser_retire got g=%0b st=%0d want 0/2", act_g, state); end
    bus.retire_valid_i = 0; tick();
    nvec++; if (act_g !== 1'b0 || state !== 2'd0) begin nerr++; $display("FAIL ser_exit got g=%0b st=%0d want 0/0", act_g, state); end
    tick();
    nvec++; if (act_g !== 1'b1) begin nerr++; $display("FAIL ser_next got %0b want 1", act_g); end
    clr_in(); retire(5'd0, 0); tick(); clr_in();
  endtask

  task automatic test_flush();
    clr_in(); issue(5'd3, 1, 3'd0, 0); tick(); issue(5'd7, 1, 3'd0, 0); tick();
    issue(5'd9, 1, 3'd0, 0); bus.flush_i = 1; tick();
    nvec++; if (act_g !== 1'b0 || state !== 2'd1) begin nerr++; $display("FAIL flush_enter got g=%0b st=%0d want 0/1", act_g, state); end
    bus.flush_i = 0; retire(5'd0, 0); repeat (2) tick();
    nvec++; if (act_g !== 1'b0 || state !== 2'd1 || pending !== 32'h88) begin
      nerr++; $display("FAIL flush_hold got g=%0b st=%0d pend=%h want 0/1/00000088", act_g, state, pending);
    end
    bus.retire_valid_i = 0; tick();
    nvec++; if (act_g !== 1'b0 || state !== 2'd0 || pending !== 32'd0) begin
      nerr++; $display("FAIL flush_exit got g=%0b st=%0d pend=%h want 0/0/0", act_g, state, pending);
    end
    tick();
    nvec++; if (act_g !== 1'b1 || pending !== 32'h200) begin nerr++; $display("FAIL flush_resume got g=%0b pend=%h want 1/00000200", act_g, pending); end
    clr_in(); retire(5'd9, 1); tick(); clr_in();
  endtask

  task automatic test_underflow_reset();
    clr_in(); retire(5'd0, 0); tick();
    nvec++; if (inflight !== 4'd0 || underflow !== 1'b1) begin nerr++; $display("FAIL underflow got inf=%0d uf=%0b want 0/1", inflight, underflow); end
    clr_in(); issue(5'd4, 1, 3'd0, 0); tick();
    clr_in(); bus.flush_i = 1; tick();
    nvec++; if (state !== 2'd1 || pending !== 32'h10 || inflight !== 4'd1) begin
      nerr++; $display("FAIL pre_reset got st=%0d pend=%h inf=%0d want 1/00000010/1", state, pending, inflight);
    end
    bus.flush_i = 0; #2 rst = 1; #1;
    nvec++; if (state !== 2'd0 || pending !== 32'd0 || inflight !== 4'd0 || underflow !== 1'b0) begin
      nerr++; $display("FAIL async_reset got st=%0d pend=%h inf=%0d uf=%0b want all 0", state, pending, inflight, underflow);
    end
    m_reset(); @(negedge clk); rst = 0; @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      clr_in();
      bus.issue_valid_i     = ($urandom_range(0, 3) != 0);
      bus.issue_rs1_i       = 5'($urandom_range(0, 7));
      bus.issue_rs1_read_i  = 1'($urandom_range(0, 1));
      bus.issue_rs2_i       = 5'($urandom_range(0, 7));
      bus.issue_rs2_read_i  = 1'($urandom_range(0, 1));
      bus.issue_rd_i        = 5'($urandom_range(0, 7));
      bus.issue_write_i     = 1'($urandom_range(0, 1));
      bus.issue_unit_i      = 3'($urandom_range(0, 7));
      bus.issue_serialize_i = ($urandom_range(0, 9) == 0);
      bus.retire_valid_i    = (m_inf > 0) && ($urandom_range(0, 2) == 0);
      bus.retire_rd_i       = 5'($urandom_range(0, 7));
      bus.retire_write_i    = 1'($urandom_range(0, 1));
      bus.ai_done_i         = ($urandom_range(0, 3) == 0);
      bus.crypto_done_i     = ($urandom_range(0, 3) == 0);
      bus.flush_i           = ($urandom_range(0, 39) == 0);
      tick();
      nvec++; if (act_g !== exp_g || act_stall !== (bus.issue_valid_i && !exp_g)) begin
        nerr++; $display("FAIL rnd_grant cyc %0d got g=%0b s=%0b want g=%0b", n, act_g, act_stall, exp_g);
      end
      nvec++; if (pending !== m_pend_vec() || inflight !== CNT_W'(m_inf)) begin
        nerr++; $display("FAIL rnd_score cyc %0d got pend=%h inf=%0d want %h/%0d", n, pending, inflight, m_pend_vec(), m_inf);
      end
      nvec++; if (state !== 2'(m_st) || underflow !== m_uf) begin
        nerr++; $display("FAIL rnd_state cyc %0d got st=%0d uf=%0b want %0d/%0b", n, state, underflow, m_st, m_uf);
      end
    end
    clr_in();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_raw();
    test_rd0_limit();
    test_ai_busy();
    test_serial();
    test_flush();
    test_underflow_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller between the decode stage and the execution units.
- Tracks in-flight register writes (one pending bit per GPR) and busy state of the multi-cycle AI and crypto units.
- Grants or withholds issue of the decoded instruction and drives the decode stall.
- Sequences pipeline drain after a flush and around serializing instructions (CSR, MRET).

Parameters:
MAX_INFLIGHT, 4, maximum instructions issued but not yet retired (range 1..15)
CNT_W, 4, width of the in-flight counter; must satisfy 2^CNT_W > MAX_INFLIGHT

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset
issue_valid_i  input  1  decode holds a valid instruction
issue_rs1_i  input  5  rs1 index
issue_rs1_read_i  input  1  instruction reads rs1
issue_rs2_i  input  5  rs2 index
issue_rs2_read_i  input  1  instruction reads rs2
issue_rd_i  input  5  rd index
issue_write_i  input  1  instruction writes rd
issue_unit_i  input  3  target unit: 0 alu, 1 branch, 2 ai, 3 crypto, 4 mem; 5-7 treated as alu
issue_serialize_i  input  1  instruction is serializing (CSR access, MRET)
issue_grant_o  output  1  combinational; instruction issues this cycle
stall_decode_o  output  1  combinational; equals issue_valid_i and not issue_grant_o
retire_valid_i  input  1  one instruction leaves write-back (killed or not)
retire_rd_i  input  5  rd of retiring instruction
retire_write_i  input  1  retiring instruction wrote rd
ai_done_i  input  1  AI unit finished its operation
crypto_done_i  input  1  crypto unit finished its operation
flush_i  input  1  pipeline controller flush request
pending_o  output  32  registered pending bits; bit 0 always 0
inflight_o  output  CNT_W  registered in-flight count
state_o  output  2  0 RUN, 1 DRAIN, 2 SERIAL
underflow_o  output  1  sticky: retire_valid_i seen with inflight 0

Behaviour:
- Clock and reset: clk_i is the single clock. rst_i is asynchronous, active-high.
- Reset values: pending 0, inflight 0, ai_busy 0, crypto_busy 0, state RUN, underflow_o 0.
- Hazard: rs1 or rs2 read and its pending bit set (RAW), or issue_write_i and rd pending (WAW). Index 0 never causes a hazard.
- Unit busy: issue_unit_i 2 while ai_busy, or 3 while crypto_busy.
- Grant condition: grant = issue_valid_i, state RUN, no flush_i, no hazard, no unit busy, inflight < MAX_INFLIGHT, and (issue_serialize_i implies inflight == 0).
- Pending bits:
  - Grant with issue_write_i and rd != 0 sets pending[rd] next edge.
  - retire_valid_i with retire_write_i clears pending[retire_rd_i].
  - Same register set and cleared in one cycle: set wins.
- In-flight counter:
  - +1 on grant, -1 on retire_valid_i; both in one cycle leaves it unchanged.
  - Retire at 0: counter holds, underflow_o set until reset.
- Busy flags:
  - ai_busy set on grant to unit 2, cleared on ai_done_i; grant and done in the same cycle leaves it set. crypto_busy behaves the same with crypto_done_i.
  - Done while not busy is ignored.
- FSM:
  - RUN: flush_i goes to DRAIN; no grant that cycle. A granted serializing instruction goes to SERIAL.
  - SERIAL: no grants. flush_i goes to DRAIN. Returns to RUN on the edge where the registered inflight == 0.
  - DRAIN: no grants; flush_i keeps it in DRAIN. Exit to RUN when registered inflight == 0, both busy flags clear and no flush_i. On that exit edge all pending bits are cleared.
- Latency: grant is combinational. Scoreboard updates are visible the next cycle. An instruction blocked only by a retiring register issues one cycle after the retire.
- Reset mid-operation: all state returns to reset values immediately; in-flight work is forgotten.

Optional Feature:
- Macro: SCB_RETIRE_BYPASS_EN.
- Defined: the hazard check ignores pending[retire_rd_i] when retire_valid_i and retire_write_i are asserted in the same cycle. A dependent instruction issues in the retire cycle; the set-wins rule re-marks rd if it is written again.
- Undefined: the hazard check uses registered pending bits only (one-cycle bubble).

Test Plan:
- Issue write x5; next cycle issue read x5 -> stall_decode_o 1 until x5 retires, then grant on the following cycle (bypass on: grant in the retire cycle).
- Issue rd=0 writes with MAX_INFLIGHT=4 -> pending_o stays 0; the 5th issue stalls until one retire, inflight_o peaks at 4.
- Issue to unit 2, then another unit-2 op -> stalled until ai_done_i; grant with done in the same cycle -> ai_busy stays 1.
- Two ops in flight, then serializing issue -> stall until inflight 0, grant, state SERIAL; next op granted only after serializing op retires.
- flush_i with x3,x7 pending and 2 in flight -> DRAIN, no grants; after 2 retires with retire_write_i 0 -> RUN, pending_o 0.
- Retire with inflight 0 -> inflight_o stays 0, underflow_o 1; assert rst_i mid-DRAIN -> all outputs at reset values immediately.
